bram_mqp: RTL and testbench

BRAM_MQP -- requirements
Module: bram_mqp

---
 rtl/bram_mqp_if.sv | 33 +++
 rtl/bram_mqp.sv | 128 ++++++++++++
 tb/tb_bram_mqp.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/bram_mqp_if.sv
// Bus bundle for the multi-port byte-enable BRAM: per-port write and read
// lanes, flattened with port p at slice p, plus the shared collision status.
interface bram_mqp_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int NPORTS = 4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = WIDTH / 8;

    logic [NPORTS-1:0]        we;
    logic [NPORTS*BW-1:0]     be;
    logic [NPORTS*AW-1:0]     addr_write;
    logic [NPORTS*WIDTH-1:0]  data_in;
    logic [NPORTS-1:0]        re;
    logic [NPORTS*AW-1:0]     addr_read;
    logic [NPORTS*WIDTH-1:0]  data_out;
    logic [NPORTS-1:0]        rvalid;
    logic                     collision;
    logic [15:0]              collision_count;

    // requester side: drives writes/reads, observes read data and status
    modport master (
        output we, be, addr_write, data_in, re, addr_read,
        input  data_out, rvalid, collision, collision_count
    );

    // memory side
    modport slave (
        input  we, be, addr_write, data_in, re, addr_read,
        output data_out, rvalid, collision, collision_count
    );
endinterface

// File: rtl/bram_mqp.sv
// Multi-port block RAM: NPORTS independent write+read pairs on one array,
// byte-enabled writes with lowest-port-wins merging, collision pulse and
// saturating collision counter, 1 or 2 cycle fully pipelined reads.
module bram_mqp #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int NPORTS     = 4,
    parameter int RD_LATENCY = 1,
    parameter int RDW_NEW    = 0,
    parameter     INIT_F     = ""
) (
    input  logic       clk,
    input  logic       rst_n,
    bram_mqp_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = WIDTH / 8;
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // per-port views of the flattened bus
    logic [NPORTS-1:0][AW-1:0]    wa;
    logic [NPORTS-1:0][AW-1:0]    ra;
    logic [NPORTS-1:0][BW-1:0]    wbe;
    logic [NPORTS-1:0][WIDTH-1:0] wd;

    assign wa  = bus.addr_write;
    assign ra  = bus.addr_read;
    assign wbe = bus.be;
    assign wd  = bus.data_in;

    // read-side pipeline: stage s holds data that is s cycles old
    logic [RD_LATENCY:1][NPORTS-1:0]            vld_pipe;
    logic [RD_LATENCY:1][NPORTS-1:0][WIDTH-1:0] dat_pipe;

    logic [NPORTS-1:0][WIDTH-1:0] rd_word;
    logic                         coll_now;
    logic                         coll_q;
    logic [15:0]                  coll_cnt;

    // addresses past DEPTH exist only when DEPTH is not a power of two
    function automatic logic in_rng(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_V;
    endfunction

    // byte-lane writes; ports are visited high to low so the lowest index
    // is assigned last and wins any shared byte, disjoint bytes all land
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n) begin
            for (int p = NPORTS-1; p >= 0; p--) begin
                for (int b = 0; b < BW; b++) begin
                    if (bus.we[p] && wbe[p][b] && in_rng(wa[p]))
                        mem[wa[p]][b*8 +: 8] <= wd[p][b*8 +: 8];
                end
            end
        end
    end

    // array read per port; with RDW_NEW the same-cycle write bytes are
    // merged on top using the same lowest-port-wins priority as the array
    always_comb begin
        rd_word = '0;
        for (int q = 0; q < NPORTS; q++) begin
            if (in_rng(ra[q])) begin
                rd_word[q] = mem[ra[q]];
                if (RDW_NEW != 0) begin
                    for (int p = NPORTS-1; p >= 0; p--) begin
                        for (int b = 0; b < BW; b++) begin
                            if (bus.we[p] && wbe[p][b] && wa[p] == ra[q])
                                rd_word[q][b*8 +: 8] = wd[p][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // collision: any port pair writing a common byte of the same address
    always_comb begin
        coll_now = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            for (int j = i + 1; j < NPORTS; j++) begin
                if (bus.we[i] && bus.we[j] && wa[i] == wa[j] && (|(wbe[i] & wbe[j])))
                    coll_now = 1'b1;
            end
        end
    end

    // read pipeline; data stages only load when their valid is set so
    // data_out holds the last returned word between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= bus.re;
            for (int q = 0; q < NPORTS; q++) begin
                if (bus.re[q])
                    dat_pipe[1][q] <= rd_word[q];
            end
            for (int s = 2; s <= RD_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                for (int q = 0; q < NPORTS; q++) begin
                    if (vld_pipe[s-1][q])
                        dat_pipe[s][q] <= dat_pipe[s-1][q];
                end
            end
        end
    end

    // one-cycle collision pulse and per-cycle saturating event count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q   <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll_q <= coll_now;
            if (coll_now && coll_cnt != 16'hFFFF)
                coll_cnt <= coll_cnt + 16'd1;
        end
    end

    assign bus.data_out        = dat_pipe[RD_LATENCY];
    assign bus.rvalid          = vld_pipe[RD_LATENCY];
    assign bus.collision       = coll_q;
    assign bus.collision_count = coll_cnt;
endmodule

// File: tb/tb_bram_mqp.sv
// Bench for bram_mqp: two instances share one stimulus stream -- one with
// 1-cycle reads returning old data on RDW, one with 2-cycle reads returning
// new data and a non-power-of-two depth -- against a word/byte array model.
module tb_bram_mqp;
    localparam int W  = 32;
    localparam int NP = 4;
    localparam int AW = 8;
    localparam int BW = 4;
    localparam int D1 = 256;
    localparam int D2 = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_mqp_if #(.WIDTH(W), .DEPTH(D1), .NPORTS(NP)) b1 ();
    bram_mqp_if #(.WIDTH(W), .DEPTH(D2), .NPORTS(NP)) b2 ();

    bram_mqp #(.WIDTH(W), .DEPTH(D1), .NPORTS(NP), .RD_LATENCY(1), .RDW_NEW(0), .INIT_F(""))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    bram_mqp #(.WIDTH(W), .DEPTH(D2), .NPORTS(NP), .RD_LATENCY(2), .RDW_NEW(1), .INIT_F(""))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    // stimulus for the current cycle
    logic [NP-1:0] i_we, i_re;
    logic [BW-1:0] i_be [NP];
    logic [AW-1:0] i_wa [NP];
    logic [AW-1:0] i_ra [NP];
    logic [W-1:0]  i_di [NP];

    // reference state
    logic [W-1:0]  m1 [D1];
    logic [W-1:0]  m2 [D1];
    logic [W-1:0]  o1 [NP];
    logic [W-1:0]  o2 [NP];
    logic [W-1:0]  p2d [NP];
    logic [NP-1:0] p2v;
    int            cnt_m;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_we = '0;
        i_re = '0;
        for (int p = 0; p < NP; p++) begin
            i_be[p] = '0; i_wa[p] = '0; i_ra[p] = '0; i_di[p] = '0;
        end
    endtask

    task automatic wr(input int p, input int a, input logic [W-1:0] d, input logic [BW-1:0] be);
        i_we[p] = 1'b1; i_wa[p] = AW'(a); i_di[p] = d; i_be[p] = be;
    endtask

    task automatic rd(input int p, input int a);
        i_re[p] = 1'b1; i_ra[p] = AW'(a);
    endtask

    task automatic drive();
        b1.we = i_we; b1.re = i_re;
        b2.we = i_we; b2.re = i_re;
        for (int p = 0; p < NP; p++) begin
            b1.be[p*BW +: BW] = i_be[p]; b2.be[p*BW +: BW] = i_be[p];
            b1.addr_write[p*AW +: AW] = i_wa[p]; b2.addr_write[p*AW +: AW] = i_wa[p];
            b1.addr_read[p*AW +: AW] = i_ra[p];  b2.addr_read[p*AW +: AW] = i_ra[p];
            b1.data_in[p*W +: W] = i_di[p];      b2.data_in[p*W +: W] = i_di[p];
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_d1"}, b1.data_out[W-1:0] | b1.data_out[2*W-1:W] | b1.data_out[3*W-1:2*W] | b1.data_out[4*W-1:3*W], '0);
        chk({tag, "_d2"}, b2.data_out[W-1:0] | b2.data_out[2*W-1:W] | b2.data_out[3*W-1:2*W] | b2.data_out[4*W-1:3*W], '0);
        chk({tag, "_v"}, 32'({b1.rvalid, b2.rvalid}), '0);
        chk({tag, "_c"}, 32'({b1.collision, b2.collision}), '0);
        chk({tag, "_n"}, 32'({b1.collision_count, b2.collision_count}), '0);
    endtask

    // one clock with rst_n high: apply the byte-claim write model, compute
    // both read flavours, advance the clock and compare every output
    task automatic step();
        logic [W-1:0] r1 [NP];
        logic [W-1:0] r2 [NP];
        logic         col;
        int           own [int];
        int           key;
        drive();
        for (int p = 0; p < NP; p++) r1[p] = m1[i_ra[p]];
        col = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (i_we[p]) begin
                for (int b = 0; b < BW; b++) begin
                    if (i_be[p][b]) begin
                        key = int'(i_wa[p]) * BW + b;
                        if (own.exists(key)) col = 1'b1;
                        else begin
                            own[key] = p;
                            m1[i_wa[p]][b*8 +: 8] = i_di[p][b*8 +: 8];
                            if (int'(i_wa[p]) < D2) m2[i_wa[p]][b*8 +: 8] = i_di[p][b*8 +: 8];
                        end
                    end
                end
            end
        end
        for (int p = 0; p < NP; p++) r2[p] = (int'(i_ra[p]) < D2) ? m2[i_ra[p]] : '0;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (i_re[p]) o1[p] = r1[p];
            if (p2v[p]) o2[p] = p2d[p];
        end
        if (col && cnt_m != 65535) cnt_m++;
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("d1_data%0d", p), b1.data_out[p*W +: W], o1[p]);
            chk($sformatf("d2_data%0d", p), b2.data_out[p*W +: W], o2[p]);
        end
        chk("d1_rvalid", 32'(b1.rvalid), 32'(i_re));
        chk("d2_rvalid", 32'(b2.rvalid), 32'(p2v));
        chk("d1_coll", 32'(b1.collision), 32'(col));
        chk("d2_coll", 32'(b2.collision), 32'(col));
        chk("d1_count", 32'(b1.collision_count), cnt_m);
        chk("d2_count", 32'(b2.collision_count), cnt_m);
        p2v = i_re;
        for (int p = 0; p < NP; p++) if (i_re[p]) p2d[p] = r2[p];
    endtask

    initial begin
        logic [W-1:0] saved;
        idle();
        drive();
        p2v = '0; cnt_m = 0;
        for (int p = 0; p < NP; p++) begin o1[p] = '0; o2[p] = '0; p2d[p] = '0; end

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // fill every word so all later reads are defined
        for (int k = 0; k < D1 / NP; k++) begin
            idle();
            for (int p = 0; p < NP; p++) wr(p, k*NP + p, $urandom(), 4'hF);
            step();
        end

        // port 0 writes, port 3 reads one cycle later
        idle(); wr(0, 5, 32'hDEADBEEF, 4'hF); step();
        idle(); rd(3, 5); step();
        chk("r021_data", b1.data_out[3*W +: W], 32'hDEADBEEF);
        chk("r021_vld", 32'(b1.rvalid[3]), 32'd1);

        // overlapping write: port 1 wins low bytes, pulse and count
        idle(); wr(1, 7, 32'h11111111, 4'b0011); wr(2, 7, 32'h22222222, 4'b1111); step();
        chk("r022_coll", 32'(b1.collision), 32'd1);
        chk("r022_cnt", 32'(b1.collision_count), 32'd1);
        idle(); rd(0, 7); step();
        chk("r022_word", b1.data_out[W-1:0], 32'h22221111);
        idle(); step();
        chk("r022_pulse_end", 32'(b1.collision), 32'd0);

        // disjoint bytes on the same word: no collision
        idle(); wr(0, 9, 32'hA0A0A0A0, 4'b0001); wr(1, 9, 32'hB1B1B1B1, 4'b0010); step();
        chk("r023_coll", 32'(b1.collision), 32'd0);
        chk("r023_cnt", 32'(b1.collision_count), 32'd1);
        idle(); rd(2, 9); step();
        chk("r023_bytes", {16'h0, b1.data_out[2*W +: 16]}, 32'h0000B1A0);

        // read-during-write: old data on dut1, new data on dut2
        idle(); wr(0, 3, 32'hAAAAAAAA, 4'hF); step();
        idle(); wr(0, 3, 32'h55555555, 4'hF); rd(1, 3); step();
        chk("r024_old", b1.data_out[W +: W], 32'hAAAAAAAA);
        idle(); step();
        chk("r024_new", b2.data_out[W +: W], 32'h55555555);

        // back-to-back reads through the 2-cycle pipe
        for (int a = 0; a < 3; a++) begin idle(); rd(0, a); step(); end
        for (int k = 0; k < 3; k++) begin idle(); step(); end

        // out-of-range on the 200-deep instance
        idle(); wr(0, 205, 32'hCAFEF00D, 4'hF); rd(1, 205); rd(2, 199); step();
        idle(); step();

        // randomized traffic on a narrow address window to provoke overlap
        for (int k = 0; k < 300; k++) begin
            idle();
            for (int p = 0; p < NP; p++) begin
                i_we[p] = 1'($urandom_range(0, 1));
                i_re[p] = 1'($urandom_range(0, 1));
                i_be[p] = BW'($urandom_range(0, 15));
                i_di[p] = $urandom();
                i_wa[p] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(195, 215) : $urandom_range(0, 15));
                i_ra[p] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(195, 215) : $urandom_range(0, 15));
            end
            step();
        end

        // reset with a 2-cycle read and a collision pulse in flight
        idle(); rd(0, 10); wr(1, 7, 32'h1, 4'h1); wr(2, 7, 32'h2, 4'h1); step();
        saved = m1[10];
        idle();
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_async");
        wr(0, 10, 32'h12345678, 4'hF);
        drive();
        @(posedge clk);
        #1 chk_zero("rst_hold");
        idle(); drive();
        rst_n = 1'b1;
        p2v = '0; cnt_m = 0;
        for (int p = 0; p < NP; p++) begin o1[p] = '0; o2[p] = '0; end
        for (int k = 0; k < 3; k++) begin idle(); step(); end
        idle(); rd(0, 10); step();
        idle(); step();
        chk("r026_mem", b2.data_out[W-1:0], saved);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
